imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 or 64 legal, and any other value SHALL fail elaboration.
REQ-002 SHALL have parameter EN_ZIMM, default 1; 1 enables decoding of the CSR zimm format.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port flush  in  1  drop all buffered entries.
REQ-006 Port in_valid  in  1  upstream has an instruction.
REQ-007 Port in_ready  out  1  stage can accept.
REQ-008 Port in_instr  in  32  raw RV instruction.
REQ-009 Port in_pc  in  XLEN  instruction address.
REQ-010 Port out_valid  out  1  result present.
REQ-011 Port out_ready  in  1  downstream accepts.
REQ-012 Port out_imm  out  XLEN  sign- or zero-extended immediate.
REQ-013 Port out_fmt  out  3  imm_fmt_t format code.
REQ-014 Port out_target  out  XLEN  in_pc+imm, modulo 2^XLEN.
REQ-015 Port out_pc  out  XLEN  pc passed through with its entry.

Function
REQ-016 Opcode-to-format map SHALL be:
- 0010011, 0000011, 1100111 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 1110011 with funct3[2]=1 and EN_ZIMM=1 -> Z
- anything else -> NONE, with imm=0.
REQ-017 Immediates SHALL be built per the RV base spec; I/S/B/U/J SHALL sign-extend instr[31] to XLEN, U SHALL included (bits 63:32 = instr[31] when XLEN=64).
REQ-018 Z SHALL zero-extend instr[19:15] to XLEN.
REQ-019 out_target SHALL be computed for every format, using the same pc and imm as that entry.
REQ-020 Transfer SHALL occur on valid&&ready at each side; out_* SHALL hold stable while out_valid&&!out_ready.
REQ-021 Latency SHALL be 1 cycle: an input accepted at edge N appears on out_* after edge N, when the pipeline is empty.
REQ-022 Storage SHALL be an output register plus a one-entry skid register; control states are EMPTY, ONE, TWO.
REQ-023 in_ready SHALL be a register output: 1 in EMPTY and ONE, 0 in TWO.
REQ-024 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept without drain -> TWO.
- ONE + drain without accept -> EMPTY.
- ONE + both -> ONE.
- TWO + drain -> ONE, with skid moving to the output register.
REQ-025 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-026 flush SHALL have priority: the next state is EMPTY, and any same-cycle input is discarded even if in_ready=1.
REQ-027 A same-cycle out_ready during flush SHALL count as consumed; the bench SHALL not check which entry.
REQ-028 out_valid SHALL be 1 exactly in ONE and TWO.

Reset
REQ-029 While rst_n=0 SHALL give: state EMPTY, out_valid=0, in_ready=0, and out_imm, out_target, out_pc, out_fmt all 0 (NONE).
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock.

Structure
REQ-032 Package core_pkg SHALL hold: imm_fmt_t enum (NONE=0, I, S, B, U, J, Z), opcode constants, and the EMPTY/ONE/TWO state enum.
REQ-033 Combinational sub-module imm_extract (parameter XLEN, EN_ZIMM; instr -> imm, fmt) SHALL be instantiated once, at the input.
REQ-034 The stage SHALL store extracted imm/fmt/pc; the target adder SHALL sit before the output register.

Verification
REQ-035 XLEN=32: 0xFFF00093, pc 0 -> imm 0xFFFFFFFF, fmt I, one cycle later.
REQ-036 XLEN=32: 0xFE000EE3, pc 0x100 -> imm 0xFFFFFFFC, fmt B, target 0x000000FC.
REQ-037 XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt U; 0x0080006F at pc 0x100 -> imm 8, fmt J, target 0x108.
REQ-038 Backpressure: out_ready=0 while 3 back-to-back valids are offered -> 2 accepted, in_ready=0 from the next cycle; release out_ready -> outputs in order, then the third is accepted.
REQ-039 flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input is never output.
REQ-040 0x3402D073 (csrrwi) with EN_ZIMM=1 -> fmt Z, imm 5; with EN_ZIMM=0 -> fmt NONE, imm 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the immediate-decode stage.
package core_pkg;

  // Immediate format code carried with every decoded entry.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // RV32/RV64 base opcodes relevant to immediate extraction.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: raw instruction -> extended immediate and format.
module imm_extract
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt
);

  logic signed [31:0] imm32;
  logic               zimm_sel;

  // Decode the opcode and assemble the 32-bit immediate; widen to XLEN at the end.
  always_comb begin
    imm32    = '0;
    fmt      = FMT_NONE;
    zimm_sel = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry a zimm field.
        if (EN_ZIMM && instr[14]) begin
          fmt      = FMT_Z;
          zimm_sel = 1'b1;
        end
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
    // Signed cast sign-extends instr[31] into the upper half on RV64.
    imm = zimm_sel ? XLEN'(instr[19:15]) : XLEN'(imm32);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// One-cycle immediate-decode pipeline stage with a skid buffer and branch-target adder.
module imm_decode_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  stage_state_t state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain, load_out, load_skid, from_skid;

  logic [XLEN-1:0]        imm_p0;
  imm_fmt_t               fmt_p0;
  logic [XLEN-1:0]        skid_imm_p1, skid_pc_p1;
  imm_fmt_t               skid_fmt_p1;
  logic signed [XLEN-1:0] imm_mux, pc_mux, target_mux;
  imm_fmt_t               fmt_mux;
  logic [XLEN-1:0]        imm_p1, pc_p1, target_p1;
  imm_fmt_t               fmt_p1;

  // ---- stage 0: extraction at the input ----
  imm_extract #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_extract (
    .instr (in_instr),
    .imm   (imm_p0),
    .fmt   (fmt_p0)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

  // Occupancy FSM: decide next state and which register loads this cycle.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
        ST_ONE: begin
          if (accept && !drain) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (!accept && drain) begin
            state_d = ST_EMPTY;
          end else if (accept && drain) begin
            load_out = 1'b1;
          end
        end
        ST_TWO: if (drain) begin
          state_d   = ST_ONE;
          load_out  = 1'b1;
          from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Control registers; in_ready is registered so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Skid register captures the entry that arrives while the output is stalled.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_p1 <= imm_p0;
      skid_fmt_p1 <= fmt_p0;
      skid_pc_p1  <= in_pc;
    end
  end

  // Select the entry headed for the output register and form its target.
  always_comb begin
    imm_mux    = from_skid ? skid_imm_p1 : imm_p0;
    pc_mux     = from_skid ? skid_pc_p1  : in_pc;
    fmt_mux    = from_skid ? skid_fmt_p1 : fmt_p0;
    target_mux = pc_mux + imm_mux;
  end

  // ---- stage 1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_p1    <= '0;
      fmt_p1    <= FMT_NONE;
      pc_p1     <= '0;
      target_p1 <= '0;
    end else if (load_out) begin
      imm_p1    <= imm_mux;
      fmt_p1    <= fmt_mux;
      pc_p1     <= pc_mux;
      target_p1 <= target_mux;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign out_imm    = imm_p1;
  assign out_fmt    = fmt_p1;
  assign out_pc     = pc_p1;
  assign out_target = target_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: RV32, RV64 and zimm-disabled instances share stimulus.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;

  logic        r32, v32, r64, v64, rnz, vnz;
  logic [31:0] imm32, tgt32, pc32o, immnz, tgtnz, pcnz;
  logic [63:0] imm64, tgt64, pc64o;
  logic [2:0]  fmt32, fmt64, fmtnz;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .EN_ZIMM(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(instr), .in_pc(pc64[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_pc(pc32o));

  imm_decode_stage #(.XLEN(64), .EN_ZIMM(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(instr), .in_pc(pc64), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_pc(pc64o));

  imm_decode_stage #(.XLEN(32), .EN_ZIMM(1'b0)) dutnz (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rnz),
    .in_instr(instr), .in_pc(pc64[31:0]), .out_valid(vnz), .out_ready(out_ready),
    .out_imm(immnz), .out_fmt(fmtnz), .out_target(tgtnz), .out_pc(pcnz));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;     // RV64 immediate; low 32 bits are the RV32 one
    logic [2:0]  fmt;
    logic [63:0] tgt;     // RV64 target
    logic [31:0] tgt32;   // RV32 target (wraps)
    logic [2:0]  fmt_nz;  // format with zimm disabled
    logic [31:0] imm_nz;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input int k);
    vec_t v;
    v = vecs[k];
    @(negedge clk);
    in_valid = 1'b1;
    instr    = v.instr;
    pc64     = v.pc;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid32", k), 64'(v32), 64'd1);
    chk($sformatf("v%0d imm32", k), 64'(imm32), 64'(v.imm[31:0]));
    chk($sformatf("v%0d fmt32", k), 64'(fmt32), 64'(v.fmt));
    chk($sformatf("v%0d tgt32", k), 64'(tgt32), 64'(v.tgt32));
    chk($sformatf("v%0d pc32", k), 64'(pc32o), 64'(v.pc[31:0]));
    chk($sformatf("v%0d imm64", k), imm64, v.imm);
    chk($sformatf("v%0d fmt64", k), 64'(fmt64), 64'(v.fmt));
    chk($sformatf("v%0d tgt64", k), tgt64, v.tgt);
    chk($sformatf("v%0d fmtnz", k), 64'(fmtnz), 64'(v.fmt_nz));
    chk($sformatf("v%0d immnz", k), 64'(immnz), 64'(v.imm_nz));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d drained", k), 64'(v32), 64'd0);
  endtask

  initial begin
    //          instr          pc                    imm                    fmt   tgt64                  tgt32          fmtnz imm_nz
    vecs[0]  = '{32'hFFF00093, 64'h0,                64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF};
    vecs[1]  = '{32'hFE000EE3, 64'h100,              64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFC,               32'h000000FC, 3'd3, 32'hFFFFFFFC};
    vecs[2]  = '{32'h800000B7, 64'h0,                64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 32'h80000000};
    vecs[3]  = '{32'h0080006F, 64'h100,              64'h8,                3'd5, 64'h108,              32'h00000108, 3'd5, 32'h00000008};
    vecs[4]  = '{32'h3402D073, 64'h200,              64'h5,                3'd6, 64'h205,              32'h00000205, 3'd0, 32'h00000000};
    vecs[5]  = '{32'hFE512C23, 64'h1000,             64'hFFFFFFFFFFFFFFF8, 3'd2, 64'hFF8,              32'h00000FF8, 3'd2, 32'hFFFFFFF8};
    vecs[6]  = '{32'h00000033, 64'h44,               64'h0,                3'd0, 64'h44,               32'h00000044, 3'd0, 32'h00000000};
    vecs[7]  = '{32'h12345017, 64'h10,               64'h12345000,         3'd4, 64'h12345010,         32'h12345010, 3'd4, 32'h12345000};
    vecs[8]  = '{32'h34029073, 64'h8,                64'h0,                3'd0, 64'h8,                32'h00000008, 3'd0, 32'h00000000};
    vecs[9]  = '{32'h00C50067, 64'h300,              64'hC,                3'd1, 64'h30C,              32'h0000030C, 3'd1, 32'h0000000C};
    vecs[10] = '{32'h0080006F, 64'h00000000FFFFFFFC, 64'h8,                3'd5, 64'h0000000100000004, 32'h00000004, 3'd5, 32'h00000008};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = 32'hFFF00093;
    pc64      = 64'h40;

    // Reset: everything cleared even with an input offered.
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 64'(v32), 64'd0);
    chk("rst in_ready", 64'(r32), 64'd0);
    chk("rst imm", 64'(imm32), 64'd0);
    chk("rst fmt", 64'(fmt32), 64'd0);
    chk("rst pc", 64'(pc32o), 64'd0);
    chk("rst target", 64'(tgt32), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("in_ready before edge", 64'(r32), 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready after edge", 64'(r32), 64'd1);
    chk("valid after rst", 64'(v32), 64'd0);

    for (int k = 0; k < NV; k++) apply(k);

    // Backpressure: three back-to-back offers with the output stalled.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h00100093; pc64 = 64'h10;
    @(posedge clk); #1;
    chk("bp ready1", 64'(r32), 64'd1);
    chk("bp pc1", 64'(pc32o), 64'h10);
    @(negedge clk);
    instr = 32'h00200093; pc64 = 64'h20;
    @(posedge clk); #1;
    chk("bp ready2", 64'(r32), 64'd0);
    chk("bp hold pc", 64'(pc32o), 64'h10);
    @(negedge clk);
    instr = 32'h00300093; pc64 = 64'h30;
    @(posedge clk); #1;
    chk("bp stall valid", 64'(v32), 64'd1);
    chk("bp stall pc", 64'(pc32o), 64'h10);
    chk("bp stall imm", 64'(imm32), 64'h1);
    chk("bp stall tgt", 64'(tgt32), 64'h11);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out2 pc", 64'(pc32o), 64'h20);
    chk("bp out2 imm", 64'(imm32), 64'h2);
    chk("bp out2 tgt", 64'(tgt32), 64'h22);
    chk("bp ready back", 64'(r32), 64'd1);
    @(posedge clk); #1;
    chk("bp out3 pc", 64'(pc32o), 64'h30);
    chk("bp out3 imm", 64'(imm32), 64'h3);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp empty", 64'(v32), 64'd0);

    // Flush while full, with a new input offered in the same cycle.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h00400093; pc64 = 64'h50;
    @(posedge clk);
    @(negedge clk);
    instr = 32'h00500093; pc64 = 64'h60;
    @(posedge clk); #1;
    chk("fl full", 64'(r32), 64'd0);
    @(negedge clk);
    flush = 1'b1;
    instr = 32'h00900093; pc64 = 64'h90;
    @(posedge clk); #1;
    chk("fl valid", 64'(v32), 64'd0);
    chk("fl in_ready", 64'(r32), 64'd1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("fl quiet%0d", c), 64'(v32), 64'd0);
      chk($sformatf("fl no pc90 %0d", c), 64'(pc32o == 32'h90), 64'd0);
    end

    // Asynchronous reset with an entry held.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h00700093; pc64 = 64'h70;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ar held", 64'(v32), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar valid", 64'(v32), 64'd0);
    chk("ar in_ready", 64'(r32), 64'd0);
    chk("ar pc", 64'(pc32o), 64'd0);
    chk("ar imm64", imm64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar recover", 64'(r32), 64'd1);
    chk("ar still empty", 64'(v32), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
